// File: rtl/regfile_mp_if.sv
// Read/write port bundle between decode/writeback and the multi-port register file.
interface regfile_mp_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned NUM_RD = 2
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                      ready;
    logic [NUM_RD-1:0]         re;
    logic [NUM_RD*AW-1:0]      ra;
    logic [NUM_RD*WIDTH-1:0]   rd;
    logic [NUM_RD-1:0]         rd_valid;
    logic                      we;
    logic [AW-1:0]             wa;
    logic [WIDTH-1:0]          wd;

    modport master (output re, ra, we, wa, wd, input ready, rd, rd_valid);
    modport slave  (input re, ra, we, wa, wd, output ready, rd, rd_valid);
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file: one write port, NUM_RD registered read ports,
// entry 0 reads as zero, same-edge write bypass, self-clearing sweep after reset.
module regfile_mp #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned NUM_RD = 2
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                    state_q, state_d;
    logic [AW-1:0]             clr_ptr_q, clr_ptr_d;
    logic                      ready_q, ready_d;
    logic [NUM_RD*WIDTH-1:0]   rd_q, rd_d;
    logic [NUM_RD-1:0]         rd_valid_q, rd_valid_d;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic                      mem_wen_c;
    logic [AW-1:0]             mem_wa_c;
    logic [WIDTH-1:0]          mem_wd_c;

    logic [AW-1:0]             ra_c [NUM_RD];

    for (genvar g = 0; g < NUM_RD; g++) begin : g_ra
        assign ra_c[g] = bus.ra[g*AW +: AW];
    end

    // Next-state, array write port and read-port update
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        ready_d    = ready_q;
        rd_d       = rd_q;
        rd_valid_d = '0;
        mem_wen_c  = 1'b0;
        mem_wa_c   = clr_ptr_q;
        mem_wd_c   = '0;

        case (state_q)
            CLEAR: begin
                mem_wen_c = 1'b1;
                clr_ptr_d = clr_ptr_q + AW'(1);
                ready_d   = 1'b0;
                rd_d      = '0;
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_d   = RUN;
                    clr_ptr_d = '0;
                    ready_d   = 1'b1;
                end
            end
            RUN: begin
                ready_d = 1'b1;
                if (bus.we && (bus.wa != '0) && (32'(bus.wa) < DEPTH)) begin
                    mem_wen_c = 1'b1;
                    mem_wa_c  = bus.wa;
                    mem_wd_c  = bus.wd;
                end
                // Out-of-range and entry-0 reads return zero; a same-edge write wins over the array
                for (int unsigned i = 0; i < NUM_RD; i++) begin
                    if (bus.re[i]) begin
                        rd_valid_d[i] = 1'b1;
                        if ((ra_c[i] == '0) || (32'(ra_c[i]) >= DEPTH)) begin
                            rd_d[i*WIDTH +: WIDTH] = '0;
                        end else if (bus.we && (bus.wa == ra_c[i])) begin
                            rd_d[i*WIDTH +: WIDTH] = bus.wd;
                        end else begin
                            rd_d[i*WIDTH +: WIDTH] = mem_q[ra_c[i]];
                        end
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            ready_q    <= 1'b0;
            rd_q       <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            ready_q    <= ready_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array; no write on an edge that samples reset
    always_ff @(posedge clk) begin
        if (!reset && mem_wen_c) begin
            mem_q[mem_wa_c] <= mem_wd_c;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.rd       = rd_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table, hand sequences and a random run against an array model.
module tb_regfile_mp;
    logic clk;
    logic reset;
    logic reset48;

    regfile_mp_if #(.WIDTH(32), .DEPTH(64), .NUM_RD(2)) bus64 ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(48), .NUM_RD(2)) bus48 ();

    regfile_mp #(.WIDTH(32), .DEPTH(64), .NUM_RD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(48), .NUM_RD(2)) dut48 (
        .clk   (clk),
        .reset (reset48),
        .bus   (bus48)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [64];
    logic [31:0] exp_rd    [2];
    logic [1:0]  exp_valid;

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [1:0]  re;
        logic [5:0]  ra0;
        logic [5:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ev;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int a = 0; a < 64; a++) model_mem[a] = 32'h0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        exp_valid = 2'b00;
    endtask

    // Drive one RUN cycle on the 64-entry instance and advance the model
    task automatic step(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                        input logic [1:0] re, input logic [5:0] ra0, input logic [5:0] ra1);
        logic [5:0] ra;
        bus64.we = we; bus64.wa = wa; bus64.wd = wd;
        bus64.re = re; bus64.ra = {ra1, ra0};
        for (int p = 0; p < 2; p++) begin
            ra = (p == 0) ? ra0 : ra1;
            if (re[p]) begin
                if (ra == 6'd0)                exp_rd[p] = 32'h0;
                else if (we && wa == ra)       exp_rd[p] = wd;
                else                           exp_rd[p] = model_mem[ra];
            end
        end
        exp_valid = re;
        if (we && wa != 6'd0) model_mem[wa] = wd;
        tick();
        bus64.we = 1'b0;
        bus64.re = 2'b00;
    endtask

    task automatic wait_ready(input bit use48, output int n);
        n = 0;
        while (n <= 200) begin
            tick();
            n++;
            if ((use48 ? bus48.ready : bus64.ready) === 1'b1) break;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".ready"},    64'(bus64.ready),    64'd0);
        check({tag, ".rd"},       64'(bus64.rd),       64'd0);
        check({tag, ".rd_valid"}, 64'(bus64.rd_valid), 64'd0);
    endtask

    initial begin
        int n;
        logic        r_we;
        logic [5:0]  r_wa, r_ra0, r_ra1;
        logic [31:0] r_wd;
        logic [1:0]  r_re;

        tbl[0]  = '{1'b1, 6'd5, 32'hDEAD_BEEF, 2'b00, 6'd0, 6'd0, 32'h0,         32'h0,         2'b00};
        tbl[1]  = '{1'b0, 6'd0, 32'h0,         2'b11, 6'd5, 6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11};
        tbl[2]  = '{1'b1, 6'd7, 32'h1234,      2'b01, 6'd7, 6'd0, 32'h1234,      32'hDEAD_BEEF, 2'b01};
        tbl[3]  = '{1'b0, 6'd0, 32'h0,         2'b11, 6'd7, 6'd7, 32'h1234,      32'h1234,      2'b11};
        tbl[4]  = '{1'b1, 6'd0, 32'hFFFF_FFFF, 2'b00, 6'd0, 6'd0, 32'h1234,      32'h1234,      2'b00};
        tbl[5]  = '{1'b0, 6'd0, 32'h0,         2'b11, 6'd0, 6'd0, 32'h0,         32'h0,         2'b11};
        tbl[6]  = '{1'b1, 6'd9, 32'hA5A5,      2'b00, 6'd0, 6'd0, 32'h0,         32'h0,         2'b00};
        tbl[7]  = '{1'b0, 6'd0, 32'h0,         2'b11, 6'd9, 6'd9, 32'hA5A5,      32'hA5A5,      2'b11};
        tbl[8]  = '{1'b0, 6'd0, 32'h0,         2'b01, 6'd5, 6'd9, 32'hDEAD_BEEF, 32'hA5A5,      2'b01};
        tbl[9]  = '{1'b0, 6'd0, 32'h0,         2'b01, 6'd7, 6'd9, 32'h1234,      32'hA5A5,      2'b01};
        tbl[10] = '{1'b1, 6'd9, 32'h0,         2'b01, 6'd9, 6'd9, 32'h0,         32'hA5A5,      2'b01};

        bus64.we = 1'b0; bus64.wa = '0; bus64.wd = '0; bus64.re = '0; bus64.ra = '0;
        bus48.we = 1'b0; bus48.wa = '0; bus48.wd = '0; bus48.re = '0; bus48.ra = '0;
        reset = 1'b1;
        reset48 = 1'b1;
        model_clear();

        // Reset, then the clear sweep must take exactly 64 cycles
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        wait_ready(1'b0, n);
        check("sweep_len", 64'(n), 64'd64);

        // Every entry reads zero from both ports
        for (int a = 0; a < 64; a++) begin
            step(1'b0, 6'd0, 32'h0, 2'b11, 6'(a), 6'(63 - a));
            check($sformatf("zero_rd0[%0d]", a), 64'(bus64.rd[31:0]),  64'd0);
            check($sformatf("zero_rd1[%0d]", a), 64'(bus64.rd[63:32]), 64'd0);
        end
        check("zero_valid", 64'(bus64.rd_valid), 64'd3);

        // Vector table: write/read, bypass, entry 0, hold on re=0
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra0, tbl[i].ra1);
            check($sformatf("vec%0d.rd0", i),   64'(bus64.rd[31:0]),  64'(tbl[i].e0));
            check($sformatf("vec%0d.rd1", i),   64'(bus64.rd[63:32]), 64'(tbl[i].e1));
            check($sformatf("vec%0d.valid", i), 64'(bus64.rd_valid),  64'(tbl[i].ev));
        end

        // Random traffic against the array model; small address range for frequent hits
        for (int c = 0; c < 300; c++) begin
            r_we  = 1'($urandom);
            r_wa  = 6'($urandom_range(0, 15));
            r_wd  = $urandom;
            r_re  = 2'($urandom);
            r_ra0 = 6'($urandom_range(0, 15));
            r_ra1 = ($urandom_range(0, 3) == 0) ? r_ra0 : 6'($urandom_range(0, 15));
            step(r_we, r_wa, r_wd, r_re, r_ra0, r_ra1);
            check($sformatf("rnd%0d.rd0", c),   64'(bus64.rd[31:0]),  64'(exp_rd[0]));
            check($sformatf("rnd%0d.rd1", c),   64'(bus64.rd[63:32]), 64'(exp_rd[1]));
            check($sformatf("rnd%0d.valid", c), 64'(bus64.rd_valid),  64'(exp_valid));
        end

        // Reset during RUN: ready drops at the next edge, sweep restarts, data gone
        step(1'b1, 6'd3, 32'hCAFE_F00D, 2'b00, 6'd0, 6'd0);
        reset = 1'b1;
        tick();
        check_reset_state("run_reset");
        reset = 1'b0;
        model_clear();
        for (int k = 0; k < 20; k++) tick();
        check("mid_sweep_ready", 64'(bus64.ready), 64'd0);

        // Reset again at sweep cycle 20: full sweep restarts from entry 0
        reset = 1'b1;
        tick();
        check_reset_state("sweep_reset");
        reset = 1'b0;
        wait_ready(1'b0, n);
        check("sweep_len_restart", 64'(n), 64'd64);
        for (int a = 1; a < 16; a++) begin
            step(1'b0, 6'd0, 32'h0, 2'b11, 6'(a), 6'(a));
            check($sformatf("post_clr_rd0[%0d]", a), 64'(bus64.rd[31:0]),  64'd0);
            check($sformatf("post_clr_rd1[%0d]", a), 64'(bus64.rd[63:32]), 64'd0);
        end

        // Non-power-of-two depth: addresses >= 48 are dropped on write and read as zero
        reset48 = 1'b0;
        wait_ready(1'b1, n);
        check("sweep_len48", 64'(n), 64'd48);
        bus48.we = 1'b1; bus48.wa = 6'd50; bus48.wd = 32'hFFFF_0050;
        tick();
        bus48.we = 1'b1; bus48.wa = 6'd47; bus48.wd = 32'h0047_C0DE;
        tick();
        bus48.we = 1'b0; bus48.re = 2'b11; bus48.ra = {6'd47, 6'd50};
        tick();
        check("d48.rd50",  64'(bus48.rd[31:0]),  64'd0);
        check("d48.rd47",  64'(bus48.rd[63:32]), 64'h0047_C0DE);
        check("d48.valid", 64'(bus48.rd_valid),  64'd3);
        bus48.we = 1'b1; bus48.wa = 6'd50; bus48.wd = 32'h0000_0123;
        bus48.re = 2'b01; bus48.ra = {6'd0, 6'd50};
        tick();
        check("d48.no_bypass_oob", 64'(bus48.rd[31:0]),  64'd0);
        check("d48.hold_rd1",      64'(bus48.rd[63:32]), 64'h0047_C0DE);
        bus48.we = 1'b0; bus48.re = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
